// File: rtl/ncbo_csi_capture_arb.sv
// NCBO CSI capture arbiter: round-robin packet arbitration over NUM_CH ingress streams,
// header capture and a 2-entry registered output skid. Define NCBO_CSI_DROP_CNT_EN for drop_cnt.
module ncbo_csi_capture_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int BVAL_W = 8,
  parameter int SRC_W = 8,
  parameter int CMD_W = 4,
  parameter logic [CMD_W-1:0] CMD_RSVD_LMTST = 4'hB,
  parameter logic [CMD_W-1:0] CMD_IOBST = 4'h9,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     csclk,
  input  logic                     srst_n,
  input  logic [NUM_CH-1:0]        in_val,
  output logic [NUM_CH-1:0]        in_rdy,
  input  logic [NUM_CH-1:0]        in_sot,
  input  logic [NUM_CH-1:0]        in_eot,
  input  logic [NUM_CH*SRC_W-1:0]  in_src,
  input  logic [NUM_CH*CMD_W-1:0]  in_cmd,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*BVAL_W-1:0] in_bval,
  input  logic [NUM_CH-1:0]        in_err,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic                     out_sot,
  output logic                     out_eot,
  output logic [CH_W-1:0]          out_ch,
  output logic [SRC_W-1:0]         out_src,
  output logic [CMD_W-1:0]         out_cmd,
  output logic                     out_wr,
  output logic [DATA_W-1:0]        out_data,
  output logic [BVAL_W-1:0]        out_bval,
`ifdef NCBO_CSI_DROP_CNT_EN
  output logic [15:0]              drop_cnt,
`endif
  output logic [1:0]               out_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RCV   = 2'b01;
  localparam logic [1:0] ERR_TRUNC = 2'b10;

  typedef struct packed {
    logic              sot;
    logic              eot;
    logic [CH_W-1:0]   ch;
    logic [SRC_W-1:0]  src;
    logic [CMD_W-1:0]  cmd;
    logic              wr;
    logic [DATA_W-1:0] data;
    logic [BVAL_W-1:0] bval;
    logic [1:0]        err;
  } beat_t;

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_lock_ch, w_lock_nxt;
  logic [CH_W-1:0]   r_rr, w_rr_nxt;
  logic [SRC_W-1:0]  r_src;
  logic [CMD_W-1:0]  r_cmd;
  logic              r_wr;
  beat_t             r_e0, r_e1, w_beat;
  logic [1:0]        r_cnt;

  logic [NUM_CH-1:0] w_cand, w_drop;
  logic              w_any_cand;
  logic [CH_W-1:0]   w_rr_ch, w_idx;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_ch;
  logic              w_space, w_pop, w_push;

  logic              w_sel_val, w_sel_sot, w_sel_eot, w_sel_err;
  logic [SRC_W-1:0]  w_sel_src;
  logic [CMD_W-1:0]  w_sel_cmd;
  logic [DATA_W-1:0] w_sel_data;
  logic [BVAL_W-1:0] w_sel_bval;

  assign w_cand = in_val & in_sot;
  assign w_drop = (r_state == ST_IDLE && srst_n) ? (in_val & ~in_sot) : '0;

  // First sot candidate at or after the rr pointer, wrapping at NUM_CH.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_any_cand = 1'b0;
    w_rr_ch    = '0;
    w_idx      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = CH_W'((int'(r_rr) + k) % NUM_CH);
      if (!w_any_cand && w_cand[w_idx]) begin
        w_any_cand = 1'b1;
        w_rr_ch    = w_idx;
      end
    end
  end

  assign w_gnt_vld = (r_state == ST_LOCK) || w_any_cand;
  assign w_gnt_ch  = (r_state == ST_LOCK) ? r_lock_ch : w_rr_ch;
  assign w_pop     = (r_cnt != 2'd0) && out_rdy;
  assign w_space   = (r_cnt != 2'd2) || w_pop;

  always_comb begin
    w_sel_val  = 1'b0;
    w_sel_sot  = 1'b0;
    w_sel_eot  = 1'b0;
    w_sel_err  = 1'b0;
    w_sel_src  = '0;
    w_sel_cmd  = '0;
    w_sel_data = '0;
    w_sel_bval = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == w_gnt_ch) begin
        w_sel_val  = in_val[c];
        w_sel_sot  = in_sot[c];
        w_sel_eot  = in_eot[c];
        w_sel_err  = in_err[c];
        w_sel_src  = in_src[c*SRC_W +: SRC_W];
        w_sel_cmd  = in_cmd[c*CMD_W +: CMD_W];
        w_sel_data = in_data[c*DATA_W +: DATA_W];
        w_sel_bval = in_bval[c*BVAL_W +: BVAL_W];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge csclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!srst_n) begin
      r_state   <= ST_IDLE;
      r_lock_ch <= '0;
      r_rr      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_nxt;
      r_rr      <= w_rr_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_ch;
    w_rr_nxt    = r_rr;
    if (w_push) begin
      w_lock_nxt = w_gnt_ch;
      if (w_sel_eot) begin
        w_state_nxt = ST_IDLE;
        w_rr_nxt    = (w_gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch + 1'b1;
      end else begin
        w_state_nxt = ST_LOCK;
      end
    end
  end

  // FSM: outputs (handshake); drops are always accepted, the grantee only with skid room
  always_comb begin
    in_rdy = '0;
    w_push = 1'b0;
    if (srst_n) begin
      in_rdy = w_drop;
      if (w_gnt_vld) in_rdy[w_gnt_ch] = w_space;
      w_push = w_gnt_vld && w_space && w_sel_val;
    end
  end

  always_comb begin
    w_beat      = '0;
    w_beat.sot  = w_sel_sot;
    w_beat.eot  = w_sel_eot;
    w_beat.ch   = w_gnt_ch;
    w_beat.data = w_sel_data;
    w_beat.bval = w_sel_bval & {BVAL_W{~w_sel_err}};
    if (w_sel_sot) begin
      w_beat.src = w_sel_src;
      w_beat.cmd = w_sel_cmd;
      w_beat.wr  = (w_sel_cmd == CMD_RSVD_LMTST) || (w_sel_cmd == CMD_IOBST);
    end else begin
      w_beat.src = r_src;
      w_beat.cmd = r_cmd;
      w_beat.wr  = r_wr;
    end
    if (w_sel_err)                             w_beat.err = ERR_RCV;
    else if (w_sel_sot && r_state == ST_LOCK)  w_beat.err = ERR_TRUNC;
    else                                       w_beat.err = ERR_NONE;
  end

  always_ff @(posedge csclk) begin
    if (!srst_n) begin
      r_src <= '0;
      r_cmd <= '0;
      r_wr  <= 1'b0;
    end else if (w_push && w_sel_sot) begin
      r_src <= w_beat.src;
      r_cmd <= w_beat.cmd;
      r_wr  <= w_beat.wr;
    end
  end

  // Shifting 2-entry skid: r_e0 is the presented head and keeps its last value once drained.
  always_ff @(posedge csclk) begin
    if (!srst_n) begin
      // NOTE: skid entries are reset because r_e0 drives the outputs directly.
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= w_beat;
          else               r_e1 <= w_beat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd2) r_e0 <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_e0 <= r_e1;
            r_e1 <= w_beat;
          end else begin
            r_e0 <= w_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_val  = (r_cnt != 2'd0);
  assign out_sot  = r_e0.sot;
  assign out_eot  = r_e0.eot;
  assign out_ch   = r_e0.ch;
  assign out_src  = r_e0.src;
  assign out_cmd  = r_e0.cmd;
  assign out_wr   = r_e0.wr;
  assign out_data = r_e0.data;
  assign out_bval = r_e0.bval;
  assign out_err  = r_e0.err;

`ifdef NCBO_CSI_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic [4:0]  w_drop_num;
  logic [16:0] w_drop_sum;

  always_comb begin
    w_drop_num = '0;
    for (int c = 0; c < NUM_CH; c++) w_drop_num = w_drop_num + 5'(w_drop[c]);
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_num);

  always_ff @(posedge csclk) begin
    if (!srst_n) r_drop_cnt <= '0;
    else         r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_ncbo_csi_capture_arb.sv
// Self-checking bench for ncbo_csi_capture_arb: directed scenarios then randomized traffic,
// all compared against a queue-based packet-level reference model.
module tb_ncbo_csi_capture_arb;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;
  localparam int BVAL_W = 8;
  localparam int SRC_W  = 8;
  localparam int CMD_W  = 4;
  localparam int CH_W   = 2;

  localparam int RDY_ALWAYS = 0;
  localparam int RDY_NEVER  = 1;
  localparam int RDY_RANDOM = 2;

  logic                     csclk = 1'b0;
  logic                     srst_n;
  logic [NUM_CH-1:0]        in_val, in_rdy, in_sot, in_eot, in_err;
  logic [NUM_CH*SRC_W-1:0]  in_src;
  logic [NUM_CH*CMD_W-1:0]  in_cmd;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH*BVAL_W-1:0] in_bval;
  logic                     out_val, out_rdy, out_sot, out_eot, out_wr;
  logic [CH_W-1:0]          out_ch;
  logic [SRC_W-1:0]         out_src;
  logic [CMD_W-1:0]         out_cmd;
  logic [DATA_W-1:0]        out_data;
  logic [BVAL_W-1:0]        out_bval;
  logic [1:0]               out_err;
`ifdef NCBO_CSI_DROP_CNT_EN
  logic [15:0]              drop_cnt;
  logic [15:0]              drop_exp;
`endif

  ncbo_csi_capture_arb dut (
    .csclk(csclk), .srst_n(srst_n),
    .in_val(in_val), .in_rdy(in_rdy), .in_sot(in_sot), .in_eot(in_eot),
    .in_src(in_src), .in_cmd(in_cmd), .in_data(in_data), .in_bval(in_bval), .in_err(in_err),
    .out_val(out_val), .out_rdy(out_rdy), .out_sot(out_sot), .out_eot(out_eot),
    .out_ch(out_ch), .out_src(out_src), .out_cmd(out_cmd), .out_wr(out_wr),
    .out_data(out_data), .out_bval(out_bval),
`ifdef NCBO_CSI_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .out_err(out_err)
  );

  always #5 csclk = ~csclk;

  typedef struct {
    logic        sot, eot, err;
    logic [7:0]  src;
    logic [3:0]  cmd;
    logic [63:0] data;
    logic [7:0]  bval;
  } in_beat_t;

  typedef struct {
    logic        sot, eot, wr;
    int          ch;
    logic [7:0]  src;
    logic [3:0]  cmd;
    logic [1:0]  err;
    logic [63:0] data;
    logic [7:0]  bval;
  } out_beat_t;

  in_beat_t          chq[NUM_CH][$];
  logic [NUM_CH-1:0] pres;
  out_beat_t         outq[$];
  int                lock, rr;
  logic [7:0]        hdr_src;
  logic [3:0]        hdr_cmd;
  logic              hdr_wr;
  int                p_val, rdy_mode;
  bit                rst_req, auto_gen;
  int                n_checks, n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic add_pkt(input int ch, input int len, input logic [7:0] src, input logic [3:0] cmd,
                         input int err_beat, input bit with_eot, input bit bval_ff);
    in_beat_t b;
    for (int i = 0; i < len; i++) begin
      b.sot  = (i == 0);
      b.eot  = with_eot && (i == len - 1);
      b.err  = (i == err_beat);
      b.src  = (i == 0) ? src : 8'($urandom);
      b.cmd  = (i == 0) ? cmd : 4'($urandom);
      b.data = {$urandom, $urandom};
      b.bval = bval_ff ? 8'hFF : 8'($urandom);
      chq[ch].push_back(b);
    end
  endtask

  task automatic add_loose(input int ch, input bit eot);
    in_beat_t b;
    b.sot = 1'b0; b.eot = eot; b.err = 1'($urandom); b.src = 8'($urandom);
    b.cmd = 4'($urandom); b.data = {$urandom, $urandom}; b.bval = 8'($urandom);
    chq[ch].push_back(b);
  endtask

  task automatic gen_random(input int ch);
    int r, len;
    logic [3:0] cmd;
    r   = $urandom_range(9);
    len = $urandom_range(1, 4);
    case ($urandom_range(3))
      0: cmd = 4'hB;
      1: cmd = 4'h9;
      default: cmd = 4'($urandom);
    endcase
    if (r == 0) add_loose(ch, 1'($urandom));
    else add_pkt(ch, len, 8'($urandom), cmd, $urandom_range(0, 7), (r != 1), 1'b0);
  endtask

  task automatic drive_inputs();
    in_beat_t b;
    for (int c = 0; c < NUM_CH; c++) begin
      in_val[c] = pres[c];
      if (pres[c]) b = chq[c][0];
      else begin
        b.sot = 1'($urandom); b.eot = 1'($urandom); b.err = 1'($urandom);
        b.src = 8'($urandom); b.cmd = 4'($urandom); b.data = {$urandom, $urandom};
        b.bval = 8'($urandom);
      end
      in_sot[c] = b.sot;
      in_eot[c] = b.eot;
      in_err[c] = b.err;
      in_src[c*SRC_W +: SRC_W]    = b.src;
      in_cmd[c*CMD_W +: CMD_W]    = b.cmd;
      in_data[c*DATA_W +: DATA_W] = b.data;
      in_bval[c*BVAL_W +: BVAL_W] = b.bval;
    end
  endtask

  task automatic check_out();
    out_beat_t e;
    check("out_val", 64'(out_val), 64'(outq.size() > 0));
    if (outq.size() > 0) begin
      e = outq[0];
      check("out_hdr", 64'({out_sot, out_eot, out_ch, out_src, out_cmd, out_wr, out_err}),
            64'({e.sot, e.eot, 2'(e.ch), e.src, e.cmd, e.wr, e.err}));
      check("out_data", out_data, e.data);
      check("out_bval", 64'(out_bval), 64'(e.bval));
    end else begin
      check("hdr_hold", 64'({out_src, out_cmd, out_wr}), 64'({hdr_src, hdr_cmd, hdr_wr}));
    end
`ifdef NCBO_CSI_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
`endif
  endtask

  // One clock: present beats, predict handshake, advance the model at the edge, check outputs.
  task automatic step();
    logic [NUM_CH-1:0] exp_rdy, drop_m;
    int        g, c;
    bit        acc, pop, space;
    in_beat_t  b;
    out_beat_t nb;
    for (int i = 0; i < NUM_CH; i++) begin
      if (auto_gen && chq[i].size() == 0) gen_random(i);
      if (!pres[i] && chq[i].size() > 0 && $urandom_range(99) < p_val) pres[i] = 1'b1;
    end
    drive_inputs();
    srst_n  = ~rst_req;
    out_rdy = (rdy_mode == RDY_ALWAYS) ? 1'b1 :
              (rdy_mode == RDY_NEVER)  ? 1'b0 : ($urandom_range(99) < 60);
    #1;
    exp_rdy = '0; drop_m = '0; g = -1; acc = 0;
    pop   = (outq.size() > 0) && out_rdy;
    space = (outq.size() < 2) || pop;
    if (!rst_req) begin
      if (lock < 0) begin
        for (int i = 0; i < NUM_CH; i++)
          if (pres[i] && !chq[i][0].sot) drop_m[i] = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
          c = (rr + k) % NUM_CH;
          if (g < 0 && pres[c] && chq[c][0].sot) g = c;
        end
      end else begin
        g = lock;
      end
      exp_rdy = drop_m;
      if (g >= 0) begin
        exp_rdy[g] = space;
        acc = space && pres[g];
      end
    end
    check("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    if (acc) begin
      b = chq[g][0];
      nb.sot  = b.sot;
      nb.eot  = b.eot;
      nb.ch   = g;
      nb.src  = b.sot ? b.src : hdr_src;
      nb.cmd  = b.sot ? b.cmd : hdr_cmd;
      nb.wr   = b.sot ? (b.cmd == 4'hB || b.cmd == 4'h9) : hdr_wr;
      nb.err  = b.err ? 2'b01 : (b.sot && lock >= 0) ? 2'b10 : 2'b00;
      nb.data = b.data;
      nb.bval = b.err ? 8'h00 : b.bval;
    end
    @(posedge csclk);
    if (rst_req) begin
      outq.delete();
      lock = -1; rr = 0;
      hdr_src = '0; hdr_cmd = '0; hdr_wr = 1'b0;
`ifdef NCBO_CSI_DROP_CNT_EN
      drop_exp = '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (drop_m[i]) begin
          void'(chq[i].pop_front());
          pres[i] = 1'b0;
`ifdef NCBO_CSI_DROP_CNT_EN
          if (drop_exp != 16'hFFFF) drop_exp = drop_exp + 16'd1;
`endif
        end
      end
      if (pop) void'(outq.pop_front());
      if (acc) begin
        outq.push_back(nb);
        void'(chq[g].pop_front());
        pres[g] = 1'b0;
        if (b.sot) begin
          hdr_src = nb.src; hdr_cmd = nb.cmd; hdr_wr = nb.wr;
        end
        if (b.eot) begin
          lock = -1;
          rr   = (g + 1) % NUM_CH;
        end else begin
          lock = g;
        end
      end
    end
    @(negedge csclk);
    check_out();
    if (rst_req) begin
      check("rst_outs", 64'({out_val, out_sot, out_eot, out_ch, out_src, out_cmd, out_wr, out_bval, out_err}), 64'd0);
      check("rst_data", out_data, 64'd0);
    end
  endtask

  function automatic bit busy();
    bit any = (outq.size() > 0);
    for (int i = 0; i < NUM_CH; i++) if (chq[i].size() > 0) any = 1'b1;
    return any;
  endfunction

  // Runs until every queued beat has been emitted; closes a packet left open without eot.
  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      if (lock >= 0 && chq[lock].size() == 0) add_loose(lock, 1'b1);
      step();
      n++;
    end
    check("drain_done", 64'(busy()), 64'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    pres = '0; lock = -1; rr = 0;
    hdr_src = '0; hdr_cmd = '0; hdr_wr = 1'b0;
`ifdef NCBO_CSI_DROP_CNT_EN
    drop_exp = '0;
`endif
    in_val = '0; in_sot = '0; in_eot = '0; in_err = '0;
    in_src = '0; in_cmd = '0; in_data = '0; in_bval = '0;
    out_rdy = 1'b0; srst_n = 1'b0;
    p_val = 100; rdy_mode = RDY_ALWAYS; auto_gen = 0;

    rst_req = 1; step(); step(); rst_req = 0;

    // simultaneous single-beat packets on ch0..2, then ch0/ch3 contention after rr reaches 3
    add_pkt(0, 1, 8'h10, 4'h1, -1, 1, 0);
    add_pkt(1, 1, 8'h11, 4'hB, -1, 1, 0);
    add_pkt(2, 1, 8'h12, 4'h9, -1, 1, 0);
    drain(20);
    add_pkt(0, 2, 8'h20, 4'h3, -1, 1, 0);
    add_pkt(3, 2, 8'h23, 4'h4, -1, 1, 0);
    drain(20);

    // write-flag decode on ch3
    add_pkt(3, 4, 8'h5A, 4'hB, -1, 1, 0);
    drain(20);
    add_pkt(3, 2, 8'h5A, 4'h2, -1, 1, 0);
    drain(20);

    // downstream stall mid-packet
    add_pkt(2, 6, 8'h77, 4'h9, -1, 1, 0);
    step(); step();
    rdy_mode = RDY_NEVER;
    repeat (3) step();
    rdy_mode = RDY_ALWAYS;
    drain(40);

    // receive error on beat 2 masks its byte valids
    add_pkt(1, 3, 8'h31, 4'h5, 1, 1, 1);
    drain(20);

    // new sot on ch0 before eot
    add_pkt(0, 2, 8'h40, 4'h6, -1, 0, 0);
    add_pkt(0, 2, 8'h41, 4'hB, -1, 1, 0);
    add_pkt(1, 1, 8'h42, 4'h7, -1, 1, 0);
    drain(30);

    // reset mid-packet: leftover third beat becomes a drop
    add_pkt(1, 3, 8'h55, 4'h9, -1, 1, 0);
    step(); step();
    rst_req = 1; step(); rst_req = 0;
    step();
    drain(20);

    // randomized traffic with stalls, stray beats, truncations and rare resets
    auto_gen = 1; p_val = 70; rdy_mode = RDY_RANDOM;
    repeat (3000) begin
      rst_req = ($urandom_range(499) == 0);
      step();
    end
    rst_req = 0; auto_gen = 0; p_val = 100; rdy_mode = RDY_ALWAYS;
    drain(400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
